// File: rtl/core_hazard_ctrl_if.sv
// Stage-status and pipe-register control bundle between the pipeline datapath and core_hazard_ctrl.
// The master side drives the stage status, and the slave side (the hazard unit) drives the pipe-register controls.
interface core_hazard_ctrl_if #(
    parameter int W_REG_ADDR = 5,
    parameter int W_CNT      = 32
);
    logic [W_REG_ADDR-1:0] i_hz_id_rs1;
    logic [W_REG_ADDR-1:0] i_hz_id_rs2;
    logic                  i_hz_id_rs1_used;
    logic                  i_hz_id_rs2_used;
    logic [W_REG_ADDR-1:0] i_hz_ex_rd;
    logic                  i_hz_ex_is_load;
    logic                  i_hz_ex_br_taken;
    logic                  i_hz_ex_mcyc;
    logic                  i_hz_mem_req;
    logic                  i_hz_mem_ack;
    logic                  i_hz_cnt_clr;

    logic                  o_hz_pc_en_n;
    logic                  o_hz_ifid_en_n;
    logic                  o_hz_ifid_clr;
    logic                  o_hz_idex_en_n;
    logic                  o_hz_idex_clr;
    logic                  o_hz_exmem_en_n;
    logic                  o_hz_exmem_clr;
    logic                  o_hz_memwb_en_n;
    logic                  o_hz_memwb_clr;
    logic [W_CNT-1:0]      o_hz_stall_cnt;

    modport master (
        output i_hz_id_rs1, i_hz_id_rs2, i_hz_id_rs1_used, i_hz_id_rs2_used,
        output i_hz_ex_rd, i_hz_ex_is_load, i_hz_ex_br_taken, i_hz_ex_mcyc,
        output i_hz_mem_req, i_hz_mem_ack, i_hz_cnt_clr,
        input  o_hz_pc_en_n, o_hz_ifid_en_n, o_hz_ifid_clr, o_hz_idex_en_n, o_hz_idex_clr,
        input  o_hz_exmem_en_n, o_hz_exmem_clr, o_hz_memwb_en_n, o_hz_memwb_clr,
        input  o_hz_stall_cnt
    );

    modport slave (
        input  i_hz_id_rs1, i_hz_id_rs2, i_hz_id_rs1_used, i_hz_id_rs2_used,
        input  i_hz_ex_rd, i_hz_ex_is_load, i_hz_ex_br_taken, i_hz_ex_mcyc,
        input  i_hz_mem_req, i_hz_mem_ack, i_hz_cnt_clr,
        output o_hz_pc_en_n, o_hz_ifid_en_n, o_hz_ifid_clr, o_hz_idex_en_n, o_hz_idex_clr,
        output o_hz_exmem_en_n, o_hz_exmem_clr, o_hz_memwb_en_n, o_hz_memwb_clr,
        output o_hz_stall_cnt
    );
endinterface

// File: rtl/core_hazard_ctrl.sv
// Pipeline hazard unit: load-use stalls, branch flushes, multi-cycle EX stalls, memory-wait stalls and a stall-cycle counter.
// Controls are combinational from FSM state and stage status, so the pipe registers act on them at the next edge.
module core_hazard_ctrl #(
    parameter int W_REG_ADDR = 5,
    parameter int N_MCYC     = 8,
    parameter int W_CNT      = 32
) (
    input  logic              i_hz_clk,
    input  logic              i_hz_rst,
    core_hazard_ctrl_if.slave hz
);

    typedef enum logic {M_IDLE, M_WAIT} mem_st_e;
    typedef enum logic {E_RUN, E_MCYC} ex_st_e;

    localparam logic [7:0] MC_INIT = 8'(N_MCYC - 2);

    mem_st_e          mem_st_q, mem_st_d;
    ex_st_e           ex_st_q, ex_st_d;
    logic [7:0]       mc_cnt_q, mc_cnt_d;
    logic [W_CNT-1:0] stall_cnt_q, stall_cnt_d;

    logic mem_stall;
    logic mc_stall;
    logic rs1_hit;
    logic rs2_hit;
    logic load_use;

    logic pc_en_n;
    logic ifid_en_n, ifid_clr;
    logic idex_en_n, idex_clr;
    logic exmem_en_n, exmem_clr;
    logic memwb_en_n, memwb_clr;

    always_comb begin
        mem_stall = ((mem_st_q == M_IDLE) && hz.i_hz_mem_req && !hz.i_hz_mem_ack) ||
                    ((mem_st_q == M_WAIT) && !hz.i_hz_mem_ack);
        mc_stall  = ((ex_st_q == E_RUN) && hz.i_hz_ex_mcyc && !mem_stall) ||
                    ((ex_st_q == E_MCYC) && (mc_cnt_q != 8'd0));
        rs1_hit   = hz.i_hz_id_rs1_used && (hz.i_hz_id_rs1 == hz.i_hz_ex_rd);
        rs2_hit   = hz.i_hz_id_rs2_used && (hz.i_hz_id_rs2 == hz.i_hz_ex_rd);
        load_use  = hz.i_hz_ex_is_load && (hz.i_hz_ex_rd != '0) && (rs1_hit || rs2_hit);
    end

    // A taken branch outranks load-use: the instruction waiting in ID is wrong-path anyway.
    always_comb begin
        pc_en_n    = 1'b0;
        ifid_en_n  = 1'b0;
        ifid_clr   = 1'b0;
        idex_en_n  = 1'b0;
        idex_clr   = 1'b0;
        exmem_en_n = 1'b0;
        exmem_clr  = 1'b0;
        memwb_en_n = 1'b0;
        memwb_clr  = 1'b0;
        if (i_hz_rst) begin
            pc_en_n    = 1'b1;
            ifid_en_n  = 1'b1;
            ifid_clr   = 1'b1;
            idex_en_n  = 1'b1;
            idex_clr   = 1'b1;
            exmem_en_n = 1'b1;
            exmem_clr  = 1'b1;
            memwb_en_n = 1'b1;
            memwb_clr  = 1'b1;
        end else if (mem_stall) begin
            pc_en_n    = 1'b1;
            ifid_en_n  = 1'b1;
            idex_en_n  = 1'b1;
            exmem_en_n = 1'b1;
            memwb_clr  = 1'b1;
        end else if (mc_stall) begin
            pc_en_n    = 1'b1;
            ifid_en_n  = 1'b1;
            idex_en_n  = 1'b1;
            exmem_clr  = 1'b1;
        end else if (hz.i_hz_ex_br_taken) begin
            ifid_clr   = 1'b1;
            idex_clr   = 1'b1;
        end else if (load_use) begin
            pc_en_n    = 1'b1;
            ifid_en_n  = 1'b1;
            idex_clr   = 1'b1;
        end
    end

    always_comb begin
        mem_st_d = mem_st_q;
        case (mem_st_q)
            M_IDLE:  if (hz.i_hz_mem_req && !hz.i_hz_mem_ack) mem_st_d = M_WAIT;
            M_WAIT:  if (hz.i_hz_mem_ack) mem_st_d = M_IDLE;
            default: mem_st_d = M_IDLE;
        endcase
    end

    // The EX sequencer only advances on cycles the memory stage is not holding the pipe.
    always_comb begin
        ex_st_d  = ex_st_q;
        mc_cnt_d = mc_cnt_q;
        if (!mem_stall) begin
            case (ex_st_q)
                E_RUN: begin
                    if (hz.i_hz_ex_mcyc) begin
                        ex_st_d  = E_MCYC;
                        mc_cnt_d = MC_INIT;
                    end
                end
                E_MCYC: begin
                    if (mc_cnt_q == 8'd0) begin
                        ex_st_d = E_RUN;
                    end else begin
                        mc_cnt_d = mc_cnt_q - 8'd1;
                    end
                end
                default: ex_st_d = E_RUN;
            endcase
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (hz.i_hz_cnt_clr) begin
            stall_cnt_d = '0;
        end else if (pc_en_n && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_hz_clk or posedge i_hz_rst) begin
        if (i_hz_rst) begin
            mem_st_q    <= M_IDLE;
            ex_st_q     <= E_RUN;
            mc_cnt_q    <= 8'd0;
            stall_cnt_q <= '0;
        end else begin
            mem_st_q    <= mem_st_d;
            ex_st_q     <= ex_st_d;
            mc_cnt_q    <= mc_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign hz.o_hz_pc_en_n    = pc_en_n;
    assign hz.o_hz_ifid_en_n  = ifid_en_n;
    assign hz.o_hz_ifid_clr   = ifid_clr;
    assign hz.o_hz_idex_en_n  = idex_en_n;
    assign hz.o_hz_idex_clr   = idex_clr;
    assign hz.o_hz_exmem_en_n = exmem_en_n;
    assign hz.o_hz_exmem_clr  = exmem_clr;
    assign hz.o_hz_memwb_en_n = memwb_en_n;
    assign hz.o_hz_memwb_clr  = memwb_clr;
    assign hz.o_hz_stall_cnt  = stall_cnt_q;

    // The bus only acknowledges a request that is being presented.
    a_ack_has_req: assert property (@(posedge i_hz_clk) disable iff (i_hz_rst)
        hz.i_hz_mem_ack |-> hz.i_hz_mem_req);

endmodule

// File: tb/tb_core_hazard_ctrl.sv
// Bench for core_hazard_ctrl: directed cases pinned by literal expectations, then randomized traffic
// checked every cycle against an abstract model (outstanding-request flag, EX-occupancy age, saturating count).
module tb_core_hazard_ctrl;
    localparam int WR   = 5;
    localparam int NM   = 8;
    localparam int WC   = 4;
    localparam int CMAX = (1 << WC) - 1;

    localparam logic [8:0] C_RST  = 9'b1_11_11_11_11;
    localparam logic [8:0] C_MEM  = 9'b1_10_10_10_01;
    localparam logic [8:0] C_MC   = 9'b1_10_10_01_00;
    localparam logic [8:0] C_BR   = 9'b0_01_01_00_00;
    localparam logic [8:0] C_LU   = 9'b1_10_01_00_00;
    localparam logic [8:0] C_NONE = 9'b0_00_00_00_00;

    logic clk = 1'b0;
    logic rst = 1'b1;

    core_hazard_ctrl_if #(.W_REG_ADDR(WR), .W_CNT(WC)) hz ();

    core_hazard_ctrl #(.W_REG_ADDR(WR), .N_MCYC(NM), .W_CNT(WC)) dut (
        .i_hz_clk (clk),
        .i_hz_rst (rst),
        .hz       (hz)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: a request is outstanding until acked; a multi-cycle op spends NM unstalled cycles in EX.
    bit m_pend = 1'b0;
    int m_age  = 0;
    int m_cnt  = 0;

    function automatic logic [8:0] dut_ctl();
        return {hz.o_hz_pc_en_n, hz.o_hz_ifid_en_n, hz.o_hz_ifid_clr,
                hz.o_hz_idex_en_n, hz.o_hz_idex_clr, hz.o_hz_exmem_en_n,
                hz.o_hz_exmem_clr, hz.o_hz_memwb_en_n, hz.o_hz_memwb_clr};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic clear_in();
        hz.i_hz_id_rs1      = '0;
        hz.i_hz_id_rs2      = '0;
        hz.i_hz_id_rs1_used = 1'b0;
        hz.i_hz_id_rs2_used = 1'b0;
        hz.i_hz_ex_rd       = '0;
        hz.i_hz_ex_is_load  = 1'b0;
        hz.i_hz_ex_br_taken = 1'b0;
        hz.i_hz_ex_mcyc     = 1'b0;
        hz.i_hz_mem_req     = 1'b0;
        hz.i_hz_mem_ack     = 1'b0;
        hz.i_hz_cnt_clr     = 1'b0;
    endtask

    task automatic model_cmp();
        bit ms, mc, lu;
        logic [8:0] e;
        if (rst) begin
            chk("rst_ctl", 32'(dut_ctl()), 32'(C_RST));
            chk("rst_cnt", 32'(hz.o_hz_stall_cnt), 0);
            m_pend = 1'b0;
            m_age  = 0;
            m_cnt  = 0;
        end else begin
            ms = (hz.i_hz_mem_req || m_pend) && !hz.i_hz_mem_ack;
            mc = !ms && (m_age > 0 || hz.i_hz_ex_mcyc) && (m_age != NM - 1);
            lu = hz.i_hz_ex_is_load && (int'(hz.i_hz_ex_rd) != 0) &&
                 ((hz.i_hz_id_rs1_used && hz.i_hz_id_rs1 == hz.i_hz_ex_rd) ||
                  (hz.i_hz_id_rs2_used && hz.i_hz_id_rs2 == hz.i_hz_ex_rd));
            if (ms)                       e = C_MEM;
            else if (mc)                  e = C_MC;
            else if (hz.i_hz_ex_br_taken) e = C_BR;
            else if (lu)                  e = C_LU;
            else                          e = C_NONE;
            chk("model_ctl", 32'(dut_ctl()), 32'(e));
            chk("model_cnt", 32'(hz.o_hz_stall_cnt), 32'(m_cnt));
            if (hz.i_hz_cnt_clr)           m_cnt = 0;
            else if (e[8] && m_cnt < CMAX) m_cnt++;
            if (hz.i_hz_mem_ack)           m_pend = 1'b0;
            else if (hz.i_hz_mem_req)      m_pend = 1'b1;
            if (!ms && (m_age > 0 || hz.i_hz_ex_mcyc))
                m_age = (m_age == NM - 1) ? 0 : m_age + 1;
        end
    endtask

    // Compare at the falling edge, then present fresh inputs just after the rising edge.
    task automatic cyc();
        @(negedge clk);
        model_cmp();
        @(posedge clk);
        #1;
        clear_in();
    endtask

    initial begin
        clear_in();
        #3;
        chk("reset_ctl", 32'(dut_ctl()), 32'(C_RST));
        chk("reset_cnt", 32'(hz.o_hz_stall_cnt), 0);
        cyc();
        rst = 1'b0;
        #2 chk("post_reset_idle", 32'(dut_ctl()), 32'(C_NONE));

        cyc();
        hz.i_hz_ex_is_load = 1'b1; hz.i_hz_ex_rd = 5'd5;
        hz.i_hz_id_rs1 = 5'd5; hz.i_hz_id_rs1_used = 1'b1;
        #2 chk("lu_ctl", 32'(dut_ctl()), 32'(C_LU));
        cyc();
        #2 chk("lu_cnt", 32'(hz.o_hz_stall_cnt), 1);

        cyc();
        hz.i_hz_ex_is_load = 1'b1; hz.i_hz_ex_rd = 5'd0;
        hz.i_hz_id_rs1 = 5'd0; hz.i_hz_id_rs1_used = 1'b1;
        #2 chk("lu_x0_ctl", 32'(dut_ctl()), 32'(C_NONE));
        cyc();
        #2 chk("lu_x0_cnt", 32'(hz.o_hz_stall_cnt), 1);

        cyc();
        hz.i_hz_ex_is_load = 1'b1; hz.i_hz_ex_rd = 5'd9;
        hz.i_hz_id_rs2 = 5'd9; hz.i_hz_id_rs2_used = 1'b1; hz.i_hz_ex_br_taken = 1'b1;
        #2 chk("br_lu_ctl", 32'(dut_ctl()), 32'(C_BR));
        cyc();
        #2 chk("br_lu_cnt", 32'(hz.o_hz_stall_cnt), 1);

        cyc(); hz.i_hz_cnt_clr = 1'b1;
        cyc();
        #2 chk("cnt_clr", 32'(hz.o_hz_stall_cnt), 0);

        for (int i = 0; i < 8; i++) begin
            cyc(); hz.i_hz_ex_mcyc = 1'b1;
            #2 chk(i < 7 ? "mc_stall" : "mc_release", 32'(dut_ctl()), 32'(i < 7 ? C_MC : C_NONE));
        end
        cyc();
        #2 chk("mc_cnt", 32'(hz.o_hz_stall_cnt), 7);

        hz.i_hz_cnt_clr = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc(); hz.i_hz_mem_req = 1'b1; hz.i_hz_mem_ack = (i == 4);
            #2 chk(i < 4 ? "mw_stall" : "mw_ack", 32'(dut_ctl()), 32'(i < 4 ? C_MEM : C_NONE));
        end
        cyc();
        #2 chk("mw_cnt", 32'(hz.o_hz_stall_cnt), 4);
        hz.i_hz_mem_req = 1'b1; hz.i_hz_mem_ack = 1'b1;
        #1 chk("req_ack_ctl", 32'(dut_ctl()), 32'(C_NONE));
        cyc();
        #2 chk("req_ack_cnt", 32'(hz.o_hz_stall_cnt), 4);

        hz.i_hz_cnt_clr = 1'b1;
        for (int i = 0; i < 11; i++) begin
            cyc(); hz.i_hz_ex_mcyc = 1'b1;
            hz.i_hz_mem_req = (i >= 4 && i <= 7); hz.i_hz_mem_ack = (i == 7);
            #2;
            if (i == 5)  chk("ovl_mem", 32'(dut_ctl()), 32'(C_MEM));
            if (i == 8)  chk("ovl_resume", 32'(dut_ctl()), 32'(C_MC));
            if (i == 10) chk("ovl_release", 32'(dut_ctl()), 32'(C_NONE));
        end
        cyc();
        #2 chk("ovl_cnt", 32'(hz.o_hz_stall_cnt), 10);

        for (int i = 0; i < 4; i++) begin
            cyc(); hz.i_hz_ex_mcyc = 1'b1; hz.i_hz_mem_req = (i >= 2);
        end
        cyc(); hz.i_hz_ex_mcyc = 1'b1; hz.i_hz_mem_req = 1'b1;
        #1 rst = 1'b1;
        #1 chk("arst_ctl", 32'(dut_ctl()), 32'(C_RST));
        chk("arst_cnt", 32'(hz.o_hz_stall_cnt), 0);
        cyc();
        rst = 1'b0;
        #2 chk("arst_idle", 32'(dut_ctl()), 32'(C_NONE));

        for (int i = 0; i < 17; i++) begin
            cyc(); hz.i_hz_mem_req = 1'b1;
        end
        cyc(); hz.i_hz_mem_req = 1'b1; hz.i_hz_cnt_clr = 1'b1;
        #2 chk("sat_cnt", 32'(hz.o_hz_stall_cnt), CMAX);
        cyc(); hz.i_hz_mem_req = 1'b1; hz.i_hz_mem_ack = 1'b1;
        #2 chk("clr_wins", 32'(hz.o_hz_stall_cnt), 0);

        for (int n = 0; n < 3000; n++) begin
            cyc();
            hz.i_hz_ex_mcyc = (m_age > 0) || ($urandom_range(0, 9) == 0);
            if (m_pend) begin
                hz.i_hz_mem_req = 1'b1;
                hz.i_hz_mem_ack = ($urandom_range(0, 2) == 0);
            end else if ($urandom_range(0, 3) == 0) begin
                hz.i_hz_mem_req = 1'b1;
                hz.i_hz_mem_ack = ($urandom_range(0, 3) == 0);
            end
            hz.i_hz_id_rs1      = 5'($urandom_range(0, 3));
            hz.i_hz_id_rs2      = 5'($urandom_range(0, 3));
            hz.i_hz_ex_rd       = 5'($urandom_range(0, 3));
            hz.i_hz_id_rs1_used = 1'($urandom_range(0, 1));
            hz.i_hz_id_rs2_used = 1'($urandom_range(0, 1));
            hz.i_hz_ex_is_load  = ($urandom_range(0, 2) == 0);
            hz.i_hz_ex_br_taken = ($urandom_range(0, 5) == 0);
            hz.i_hz_cnt_clr     = ($urandom_range(0, 49) == 0);
        end
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
